// File: rtl/main_controller.sv
// main_controller: USB3300 sniffer sequencer executing op-stack commands (ULPI regs, UART forwarding); optional FORCE_SEND_EN macro enables force_send
module main_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        force_send,
    input  logic [15:0] op_stack_msg,
    input  logic        op_stack_empty,
    output logic        op_stack_pull,
    input  logic [7:0]  ULPI_USB_DATA,
    input  logic [15:0] ULPI_USB_INFO_DATA,
    input  logic        ULPI_DATA_buff_empty,
    input  logic        ULPI_INFO_buff_empty,
    output logic        ULPI_DATA_re,
    output logic        ULPI_INFO_re,
    input  logic        ULPI_busy,
    input  logic [7:0]  ULPI_REG_VAL_R,
    output logic [7:0]  ULPI_REG_VAL_W,
    output logic [5:0]  ULPI_ADDR,
    output logic        ULPI_PrW,
    output logic        ULPI_PrR,
    input  logic        UART_Tx_FULL,
    output logic [7:0]  UART_Tx_DATA,
    output logic        UART_send
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] DECODE     = 4'd1;
    localparam logic [3:0] REG_RD     = 4'd2;
    localparam logic [3:0] REG_WR     = 4'd3;
    localparam logic [3:0] SEND_REG   = 4'd4;
    localparam logic [3:0] RECV_SEND1 = 4'd5;
    localparam logic [3:0] RECV_SEND2 = 4'd6;
    localparam logic [3:0] RECV_WAIT  = 4'd7;
`ifdef FORCE_SEND_EN
    localparam logic [3:0] FORCE      = 4'd8;
`else
    logic unused_force;
    assign unused_force = force_send;
`endif
    logic [3:0]  state;
    logic [15:0] msg;
    logic [15:0] info;
    logic [7:0]  count;
    // Command sequencer; strobes default low so each one lasts a single cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            msg            <= '0;
            info           <= '0;
            count          <= '0;
            op_stack_pull  <= 1'b0;
            ULPI_DATA_re   <= 1'b0;
            ULPI_INFO_re   <= 1'b0;
            ULPI_REG_VAL_W <= '0;
            ULPI_ADDR      <= '0;
            ULPI_PrW       <= 1'b0;
            ULPI_PrR       <= 1'b0;
            UART_Tx_DATA   <= '0;
            UART_send      <= 1'b0;
        end else begin
            op_stack_pull <= 1'b0;
            ULPI_DATA_re  <= 1'b0;
            ULPI_INFO_re  <= 1'b0;
            ULPI_PrW      <= 1'b0;
            ULPI_PrR      <= 1'b0;
            UART_send     <= 1'b0;
            case (state)
                IDLE: begin
`ifdef FORCE_SEND_EN
                    if (force_send) state <= FORCE;
                    else
`endif
                    if (!op_stack_empty) begin
                        op_stack_pull <= 1'b1;
                        msg           <= op_stack_msg;
                        state         <= DECODE;
                    end
                end
                DECODE: begin
                    case (msg[15:14])
                        2'b11: state <= REG_RD;
                        2'b10: state <= REG_WR;
                        2'b01: state <= SEND_REG;
                        default: begin
                            if (ULPI_INFO_buff_empty) state <= IDLE;
                            else begin
                                info         <= ULPI_USB_INFO_DATA;
                                count        <= ULPI_USB_INFO_DATA[7:0];
                                ULPI_INFO_re <= 1'b1;
                                state        <= RECV_SEND1;
                            end
                        end
                    endcase
                end
                REG_RD: begin
                    if (!ULPI_busy) begin
                        ULPI_ADDR <= msg[13:8];
                        ULPI_PrR  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                REG_WR: begin
                    if (!ULPI_busy) begin
                        ULPI_ADDR      <= msg[13:8];
                        ULPI_REG_VAL_W <= msg[7:0];
                        ULPI_PrW       <= 1'b1;
                        state          <= IDLE;
                    end
                end
                SEND_REG: begin
                    if (!UART_Tx_FULL) begin
                        UART_Tx_DATA <= ULPI_REG_VAL_R;
                        UART_send    <= 1'b1;
                        state        <= IDLE;
                    end
                end
                RECV_SEND1: begin
                    if (!UART_Tx_FULL) begin
                        UART_Tx_DATA <= info[15:8];
                        UART_send    <= 1'b1;
                        state        <= RECV_SEND2;
                    end
                end
                RECV_SEND2: begin
                    if (!UART_Tx_FULL) begin
                        UART_Tx_DATA <= info[7:0];
                        UART_send    <= 1'b1;
                        state        <= (count == 8'd0) ? IDLE : RECV_WAIT;
                    end
                end
                RECV_WAIT: begin
                    // Skip the cycle where a pop is still in flight so the stale head is never resent
                    if (count == 8'd0) state <= IDLE;
                    else if (!ULPI_DATA_buff_empty && !UART_Tx_FULL && !ULPI_DATA_re) begin
                        UART_Tx_DATA <= ULPI_USB_DATA;
                        UART_send    <= 1'b1;
                        ULPI_DATA_re <= 1'b1;
                        count        <= count - 8'd1;
                        if (count == 8'd1) state <= IDLE;
                    end
                end
`ifdef FORCE_SEND_EN
                FORCE: begin
                    if (!UART_Tx_FULL) begin
                        UART_Tx_DATA <= ULPI_REG_VAL_R;
                        UART_send    <= 1'b1;
                        state        <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_main_controller.sv
// tb_main_controller: directed and randomized checks of main_controller against a transaction-level model
module tb_main_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        force_send = 1'b0;
    logic [15:0] op_stack_msg = '0;
    logic        op_stack_empty = 1'b1;
    logic        op_stack_pull;
    logic [7:0]  ULPI_USB_DATA = '0;
    logic [15:0] ULPI_USB_INFO_DATA = '0;
    logic        ULPI_DATA_buff_empty = 1'b1;
    logic        ULPI_INFO_buff_empty = 1'b1;
    logic        ULPI_DATA_re, ULPI_INFO_re;
    logic        ULPI_busy = 1'b0;
    logic [7:0]  ULPI_REG_VAL_R = '0;
    logic [7:0]  ULPI_REG_VAL_W;
    logic [5:0]  ULPI_ADDR;
    logic        ULPI_PrW, ULPI_PrR;
    logic        UART_Tx_FULL = 1'b0;
    logic [7:0]  UART_Tx_DATA;
    logic        UART_send;

    main_controller dut (
        .clk(clk), .rst(rst), .force_send(force_send),
        .op_stack_msg(op_stack_msg), .op_stack_empty(op_stack_empty), .op_stack_pull(op_stack_pull),
        .ULPI_USB_DATA(ULPI_USB_DATA), .ULPI_USB_INFO_DATA(ULPI_USB_INFO_DATA),
        .ULPI_DATA_buff_empty(ULPI_DATA_buff_empty), .ULPI_INFO_buff_empty(ULPI_INFO_buff_empty),
        .ULPI_DATA_re(ULPI_DATA_re), .ULPI_INFO_re(ULPI_INFO_re), .ULPI_busy(ULPI_busy),
        .ULPI_REG_VAL_R(ULPI_REG_VAL_R), .ULPI_REG_VAL_W(ULPI_REG_VAL_W), .ULPI_ADDR(ULPI_ADDR),
        .ULPI_PrW(ULPI_PrW), .ULPI_PrR(ULPI_PrR), .UART_Tx_FULL(UART_Tx_FULL),
        .UART_Tx_DATA(UART_Tx_DATA), .UART_send(UART_send)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int pull_n = 0, prr_n = 0, prw_n = 0, info_n = 0, data_n = 0;
    int e_pull = 0, e_prr = 0, e_prw = 0, e_info = 0, e_data = 0;
    logic [5:0] e_addr = '0;
    logic [7:0] e_valw = '0;
    logic [7:0] got[$], exp_q[$], data_q[$];
    logic [15:0] info_q[$];
    logic full_s = 1'b0, busy_s = 1'b0, rand_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        full_s <= UART_Tx_FULL;
        busy_s <= ULPI_busy;
    end

    // Buffer/stack models and protocol watch, sampled mid-cycle
    always @(negedge clk) begin
        if (op_stack_pull) begin pull_n++; op_stack_empty = 1'b1; end
        if (ULPI_PrR) begin prr_n++; chk("prr_while_busy", {31'd0, busy_s}, 0); end
        if (ULPI_PrW) begin prw_n++; chk("prw_while_busy", {31'd0, busy_s}, 0); end
        if (UART_send) begin got.push_back(UART_Tx_DATA); chk("send_while_full", {31'd0, full_s}, 0); end
        if (ULPI_INFO_re) begin info_n++; if (info_q.size() > 0) void'(info_q.pop_front()); end
        if (ULPI_DATA_re) begin
            data_n++;
            chk("data_re_while_full", {31'd0, full_s}, 0);
            if (data_q.size() > 0) void'(data_q.pop_front());
        end
        ULPI_USB_DATA        = data_q.size() > 0 ? data_q[0] : 8'd0;
        ULPI_DATA_buff_empty = data_q.size() == 0;
        ULPI_USB_INFO_DATA   = info_q.size() > 0 ? info_q[0] : 16'd0;
        ULPI_INFO_buff_empty = info_q.size() == 0;
        if (rand_en) begin
            UART_Tx_FULL = $urandom_range(3) == 0;
            ULPI_busy    = $urandom_range(3) == 0;
        end
    end

    task automatic issue(input logic [15:0] op);
        op_stack_msg   = op;
        op_stack_empty = 1'b0;
        e_pull++;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_pull"}, pull_n, e_pull);
        chk({tag, "_prr"}, prr_n, e_prr);
        chk({tag, "_prw"}, prw_n, e_prw);
        chk({tag, "_info_re"}, info_n, e_info);
        chk({tag, "_data_re"}, data_n, e_data);
        chk({tag, "_addr"}, {26'd0, ULPI_ADDR}, {26'd0, e_addr});
        chk({tag, "_valw"}, {24'd0, ULPI_REG_VAL_W}, {24'd0, e_valw});
        chk({tag, "_nbytes"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk({tag, "_byte"}, {24'd0, got[i]}, {24'd0, exp_q[i]});
        got.delete();
        exp_q.delete();
    endtask

    task automatic add_packet(input logic [7:0] st, input int n);
        info_q.push_back({st, 8'(n)});
        exp_q.push_back(st);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            logic [7:0] b = 8'($urandom);
            data_q.push_back(b);
            exp_q.push_back(b);
        end
        e_info++;
        e_data += n;
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        data_q.push_back(b0); data_q.push_back(b1); data_q.push_back(b2);
    endtask

    initial begin
        int k;
        #3 rst = 1'b0;
        #1;
        chk("reset_outputs", {4'd0, op_stack_pull, ULPI_DATA_re, ULPI_INFO_re, ULPI_PrW, ULPI_PrR, UART_send,
                              ULPI_REG_VAL_W, ULPI_ADDR, UART_Tx_DATA}, 0);
        tick; tick;
        rst = 1'b1;
        tick;
        issue(16'hE196); e_prr++; e_addr = 6'h21;
        repeat (8) tick;
        check_all("reg_rd");
        issue(16'hA296); e_prw++; e_addr = 6'h22; e_valw = 8'h96;
        repeat (8) tick;
        check_all("reg_wr");
        ULPI_REG_VAL_R = 8'hCA;
        issue(16'h6396); exp_q.push_back(8'hCA);
        repeat (8) tick;
        check_all("send_reg");
        ULPI_busy = 1'b1;
        issue(16'hE196); e_addr = 6'h21;
        repeat (4) tick;
        chk("busy_holds_prr", prr_n, e_prr);
        ULPI_busy = 1'b0; e_prr++;
        repeat (5) tick;
        check_all("busy_rd");
        UART_Tx_FULL = 1'b1;
        issue(16'h6396);
        repeat (6) tick;
        chk("full_holds_send", got.size(), 0);
        UART_Tx_FULL = 1'b0; exp_q.push_back(8'hCA);
        repeat (5) tick;
        check_all("full_send");
        info_q.push_back(16'hC403); set_bytes(8'hAC, 8'hBC, 8'hCC);
        exp_q = '{8'hC4, 8'h03, 8'hAC, 8'hBC, 8'hCC}; e_info++; e_data += 3;
        issue(16'h2196);
        repeat (20) tick;
        check_all("recv3");
        info_q.push_back(16'hC400); exp_q = '{8'hC4, 8'h00}; e_info++;
        issue(16'h2196);
        repeat (10) tick;
        check_all("recv0");
        issue(16'h0000);
        repeat (8) tick;
        check_all("recv_empty");
`ifdef FORCE_SEND_EN
        ULPI_REG_VAL_R = 8'h68;
        force_send = 1'b1;
        tick;
        force_send = 1'b0;
        exp_q.push_back(8'h68);
        repeat (6) tick;
        check_all("force");
`else
        ULPI_REG_VAL_R = 8'h68;
        force_send = 1'b1;
        repeat (10) tick;
        force_send = 1'b0;
        check_all("force_ignored");
`endif
        for (int n = 0; n < 40; n++) begin
            logic [1:0]  opc = 2'($urandom);
            logic [15:0] op  = {opc, 6'($urandom), 8'($urandom)};
            int          cnt = 0;
            ULPI_REG_VAL_R = 8'($urandom);
            if (opc == 2'b11) begin e_prr++; e_addr = op[13:8]; end
            else if (opc == 2'b10) begin e_prw++; e_addr = op[13:8]; e_valw = op[7:0]; end
            else if (opc == 2'b01) exp_q.push_back(ULPI_REG_VAL_R);
            else if ($urandom_range(3) != 0) begin
                cnt = $urandom_range(6);
                add_packet(8'($urandom), cnt);
            end
            issue(op);
            rand_en = 1'b1;
            repeat (30) tick;
            rand_en = 1'b0; UART_Tx_FULL = 1'b0; ULPI_busy = 1'b0;
            repeat (20 + 3 * cnt) tick;
            check_all("random");
            chk("random_data_left", data_q.size(), 0);
        end
        add_packet(8'h05, 8);
        issue(16'h0000);
        rand_en = 1'b1;
        for (int i = 0; i < 400 && got.size() < 5; i++) tick;
        chk("mid_recv_progress", {31'd0, got.size() >= 5}, 1);
        rst = 1'b0;
        #1;
        chk("midrst_outputs", {4'd0, op_stack_pull, ULPI_DATA_re, ULPI_INFO_re, ULPI_PrW, ULPI_PrR, UART_send,
                               ULPI_REG_VAL_W, ULPI_ADDR, UART_Tx_DATA}, 0);
        rand_en = 1'b0; UART_Tx_FULL = 1'b0; ULPI_busy = 1'b0;
        k = got.size();
        repeat (3) tick;
        rst = 1'b1;
        data_q.delete();
        repeat (20) tick;
        chk("no_bytes_after_rst", got.size(), k);
        chk("pops_match_payload_sent", data_n - (e_data - 8), k - 2);
        for (int i = 0; i < got.size(); i++) chk("midrst_prefix", {24'd0, got[i]}, {24'd0, exp_q[i]});
        got.delete(); exp_q.delete();
        e_data = data_n; e_addr = '0; e_valw = '0;
        issue(16'hA5C3); e_prw++; e_addr = 6'h25; e_valw = 8'hC3;
        repeat (8) tick;
        check_all("after_rst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
